// File: rtl/longprach_path_pkg.sv
// Shared path-string types and the basename truncation function.
// path_truncate is the reference for what the streaming packer must produce with truncation on.
package longprach_path_pkg;

    localparam int        PATH_MAX_CHARS = 512;
    localparam logic [7:0] PATH_SEP      = 8'h2F;

    typedef logic [8*PATH_MAX_CHARS-1:0] path_str_t;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } packer_state_t;

    // The string is right-aligned, so scanning up from [7:0] meets the final separator first.
    function automatic path_str_t path_truncate(input path_str_t s);
        path_str_t r;
        logic      hit;
        r   = s;
        hit = 1'b0;
        for (int i = 0; i < PATH_MAX_CHARS; i++) begin
            if (s[8*i +: 8] == PATH_SEP) hit = 1'b1;
            if (hit) r[8*i +: 8] = 8'h00;
        end
        return r;
    endfunction

endpackage

// File: rtl/longprach_path_str_packer.sv
// Packs a last-flagged byte stream into a right-aligned string, optionally keeping only the basename.
// Latency: out_valid the cycle after the last beat; backpressure: in_ready low while the result is held.
module longprach_path_str_packer
    import longprach_path_pkg::*;
#(
    parameter int         MAX_CHARS    = PATH_MAX_CHARS,
    parameter logic [7:0] SEP_CHAR     = PATH_SEP,
    parameter bit         TRUNC_AT_SEP = 1'b1
) (
    input  logic                           clk,
    input  logic                           areset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [7:0]                     in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [8*MAX_CHARS-1:0]         out_str,
    output logic [$clog2(MAX_CHARS+1)-1:0] out_len,
    output logic                           out_overflow,
    output logic                           out_sep_seen
);

    localparam int STR_W = 8 * MAX_CHARS;
    localparam int LEN_W = $clog2(MAX_CHARS + 1);

    packer_state_t state_q, state_d;
    logic [STR_W-1:0] str_q, str_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             sep_q, sep_d;

    always_comb begin
        state_d = state_q;
        str_d   = str_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        sep_d   = sep_q;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    if (in_data == 8'h00) begin
                        // NUL bytes never reach the string; in_last still closes the path.
                    end else if (in_data == SEP_CHAR && TRUNC_AT_SEP) begin
                        str_d = '0;
                        len_d = '0;
                        sep_d = 1'b1;
                    end else begin
                        if (in_data == SEP_CHAR) sep_d = 1'b1;
                        if (len_q < LEN_W'(MAX_CHARS)) begin
                            str_d = {str_q[STR_W-9:0], in_data};
                            len_d = len_q + LEN_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (in_last) state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = COLLECT;
                    str_d   = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    sep_d   = 1'b0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= COLLECT;
            str_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            sep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            str_q   <= str_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            sep_q   <= sep_d;
        end
    end

    assign in_ready     = (state_q == COLLECT);
    assign out_valid    = (state_q == HOLD);
    assign out_str      = str_q;
    assign out_len      = len_q;
    assign out_overflow = ovf_q;
    assign out_sep_seen = sep_q;

endmodule

// File: tb/tb_longprach_path_str_packer.sv
// Directed bench: truncating packer plus a verbatim (no-truncation) twin fed the same stream.
module tb_longprach_path_str_packer;
    import longprach_path_pkg::*;

    logic        clk = 1'b0;
    logic        areset;
    logic        in_valid, in_last, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, out_overflow, out_sep_seen;
    path_str_t   out_str;
    logic [9:0]  out_len;
    logic        nt_in_ready, nt_out_valid, nt_out_overflow, nt_out_sep_seen;
    path_str_t   nt_out_str;
    logic [9:0]  nt_out_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    longprach_path_str_packer dut (
        .clk(clk), .areset(areset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_str(out_str), .out_len(out_len),
        .out_overflow(out_overflow), .out_sep_seen(out_sep_seen)
    );

    longprach_path_str_packer #(.TRUNC_AT_SEP(1'b0)) dut_nt (
        .clk(clk), .areset(areset),
        .in_valid(in_valid), .in_ready(nt_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(nt_out_valid), .out_ready(out_ready), .out_str(nt_out_str), .out_len(nt_out_len),
        .out_overflow(nt_out_overflow), .out_sep_seen(nt_out_sep_seen)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic path_str_t pack(input string s);
        path_str_t r = '0;
        for (int i = 0; i < s.len(); i++) r = {r[8*PATH_MAX_CHARS-9:0], s[i]};
        return r;
    endfunction

    // Presents one byte at the negedge; returns after the posedge that consumes it.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
        end else begin
            in_valid = 1'b1;
            in_data  = d;
            in_last  = last;
            @(posedge clk);
        end
    endtask

    task automatic send_str(input string s, input logic last_on_end);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last_on_end && (i == s.len() - 1));
    endtask

    // Completes the output handshake with the source idle.
    task automatic pop();
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic idle_and_settle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    path_str_t exp_str;
    logic      hold_ok;

    initial begin
        areset    = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_len",       64'(out_len),   64'd0);
        check("rst_str_zero",  64'(out_str == '0), 64'd1);
        areset = 1'b0;

        // 1: "abc", out_valid the cycle after the last beat
        send_str("abc", 1'b1);
        idle_and_settle();
        check("t1_valid",   64'(out_valid), 64'd1);
        check("t1_len",     64'(out_len),   64'd3);
        exp_str = '0;
        exp_str[23:0] = 24'h616263;
        check("t1_str",     64'(out_str == exp_str), 64'd1);
        check("t1_sep",     64'(out_sep_seen), 64'd0);
        pop();
        check("t1_clr_valid", 64'(out_valid), 64'd0);
        check("t1_clr_ready", 64'(in_ready),  64'd1);
        check("t1_clr_len",   64'(out_len),   64'd0);

        // 2: basename of a relative path, matches the package reference
        send_str("../../rtl/x.hex", 1'b1);
        idle_and_settle();
        check("t2_str_ref", 64'(out_str == path_truncate(pack("../../rtl/x.hex"))), 64'd1);
        check("t2_str_low", out_str[63:0], 64'h0000_0078_2E68_6578);
        check("t2_len",     64'(out_len),      64'd5);
        check("t2_sep",     64'(out_sep_seen), 64'd1);
        check("t2_nt_len",  64'(nt_out_len),   64'd15);
        pop();

        // 3: overflow by three characters
        for (int i = 0; i < PATH_MAX_CHARS + 3; i++)
            send_byte(8'h41, i == PATH_MAX_CHARS + 2);
        idle_and_settle();
        check("t3_len",  64'(out_len),      64'd512);
        check("t3_ovf",  64'(out_overflow), 64'd1);
        check("t3_str",  64'(out_str == {PATH_MAX_CHARS{8'h41}}), 64'd1);
        pop();
        send_str("z", 1'b1);
        idle_and_settle();
        check("t3_next_ovf", 64'(out_overflow), 64'd0);
        check("t3_next_len", 64'(out_len),      64'd1);
        pop();

        // 4: held result under backpressure with the source still pushing
        send_byte(8'h71, 1'b1);
        @(negedge clk);
        in_data = 8'h72;
        in_last = 1'b1;
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (in_ready || !out_valid || out_len != 10'd1 || out_str[15:0] != 16'h0071)
                hold_ok = 1'b0;
            @(negedge clk);
        end
        check("t4_hold_stable", 64'(hold_ok), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t4_ready_after", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("t4_next_valid", 64'(out_valid), 64'd1);
        check("t4_next_str",   out_str[63:0], 64'h72);
        pop();

        // 5: reset in the middle of a path
        send_str("abcd", 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        areset   = 1'b1;
        #1;
        check("t5_rst_len",   64'(out_len),   64'd0);
        check("t5_rst_str",   64'(out_str == '0), 64'd1);
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        check("t5_ready", 64'(in_ready), 64'd1);
        send_str("z", 1'b1);
        idle_and_settle();
        check("t5_len", 64'(out_len), 64'd1);
        exp_str = '0;
        exp_str[7:0] = 8'h7A;
        check("t5_str", 64'(out_str == exp_str), 64'd1);
        pop();

        // 6: trailing separator, with and without truncation; NUL is skipped
        send_byte(8'h00, 1'b0);
        send_str("dir/", 1'b1);
        idle_and_settle();
        check("t6_valid",   64'(out_valid), 64'd1);
        check("t6_len",     64'(out_len),   64'd0);
        check("t6_str",     64'(out_str == '0), 64'd1);
        check("t6_sep",     64'(out_sep_seen), 64'd1);
        check("t6_nt_len",  64'(nt_out_len),   64'd4);
        check("t6_nt_str",  nt_out_str[63:0], 64'h6469_722F);
        check("t6_nt_sep",  64'(nt_out_sep_seen), 64'd1);
        pop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
